// File: rtl/button_conditioner.sv
// Push-button conditioner: pad synchroniser, debounce FSM, one-cycle press pulse,
// debounced level and one-shot long-press pulse, all in the clk domain.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  output logic button,
  output logic button_level,
  output logic button_long
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                press_nxt, long_nxt, level_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let later stages see this edge's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold_cnt;
    press_nxt = 1'b0;
    long_nxt  = 1'b0;
    unique case (state)
      RELEASED: begin
        if (s) begin
          state_nxt = PRESS_CHECK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHECK: begin
        if (!s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          hold_nxt  = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_CHECK;
          cnt_nxt   = '0;
        end else begin
          // Saturating at LONG_CYCLES is what makes the long pulse one-shot.
          if (hold_cnt == HOLD_LAST) long_nxt = 1'b1;
          if (hold_cnt < HOLD_MAX)   hold_nxt = hold_cnt + 1'b1;
        end
      end
      RELEASE_CHECK: begin
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RELEASED;
      cnt          <= '0;
      hold_cnt     <= '0;
      button       <= 1'b0;
      button_level <= 1'b0;
      button_long  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hold_cnt     <= hold_nxt;
      button       <= press_nxt;
      button_level <= level_nxt;
      button_long  <= long_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: per-edge expected outputs are queued
// as stimulus is driven and popped/compared after each active edge.
module tb_button_conditioner;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int LC = 8;
  localparam int LAT = SS + DC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button_raw = 1'b0;
  logic button, button_level, button_long;

  typedef struct packed {
    logic b;
    logic lvl;
    logic lng;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;

  button_conditioner #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .button_raw(button_raw),
    .button(button),
    .button_level(button_level),
    .button_long(button_long)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Drive raw for one edge, queue the expected outputs after that edge, compare.
  task automatic drive_step(input string tag, input logic raw,
                            input logic b, input logic lvl, input logic lng);
    exp_t e;
    button_raw = raw;
    exp_q.push_back('{b: b, lvl: lvl, lng: lng});
    @(posedge clk);
    #1;
    cyc++;
    if (button === 1'b1) pulse_cnt++;
    e = exp_q.pop_front();
    check({tag, ".button"}, button, e.b);
    check({tag, ".level"}, button_level, e.lvl);
    check({tag, ".long"}, button_long, e.lng);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".button"}, button, 1'b0);
    check({tag, ".level"}, button_level, 1'b0);
    check({tag, ".long"}, button_long, 1'b0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    button_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Clean press at edge 10, release first sampled at edge 40
    for (int i = 0; i < 56; i++)
      drive_step("t1_clean", (i >= 10 && i < 40), (i == 10 + LAT),
                 (i >= 10 + LAT && i < 40 + LAT), (i == 10 + LAT + LC));

    // 2. Press bounce 1,1,0,1,1,0 then steady 1 from edge 16 to 25
    for (int i = 0; i < 46; i++) begin
      logic raw;
      raw = 1'b0;
      if (i == 10 || i == 11 || i == 13 || i == 14) raw = 1'b1;
      if (i >= 16 && i < 26) raw = 1'b1;
      drive_step("t2_bounce", raw, (i == 16 + LAT),
                 (i >= 16 + LAT && i < 26 + LAT), 1'b0);
    end

    // 3. Glitch shorter than the debounce window
    for (int i = 0; i < 35; i++)
      drive_step("t3_glitch", (i >= 10 && i < 13), 1'b0, 1'b0, 1'b0);

    // 4. Release bounce: low 40-41, high 42, steady low from 43
    pulse_cnt = 0;
    for (int i = 0; i < 61; i++)
      drive_step("t4_rel_bounce", ((i >= 10 && i < 40) || i == 42),
                 (i == 10 + LAT), (i >= 10 + LAT && i < 43 + LAT),
                 (i == 10 + LAT + LC));
    check("t4_single_pulse", (pulse_cnt == 1), 1'b1);

    // 5a. Reset asserted mid PRESS_CHECK
    for (int i = 0; i < 14; i++)
      drive_step("t5a_pre", (i >= 10), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5a_rst");
    button_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++)
      drive_step("t5a_post", 1'b0, 1'b0, 1'b0, 1'b0);

    // 5b. Reset asserted while the press pulse is high
    for (int i = 0; i < 17; i++)
      drive_step("t5b_pre", (i >= 10), (i == 10 + LAT), (i == 10 + LAT), 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5b_rst");
    button_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++)
      drive_step("t5b_post", 1'b0, 1'b0, 1'b0, 1'b0);

    // 5c. Button held through reset deassertion counts as a new press
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    button_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("t5c_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 36; i++)
      drive_step("t5c_held", (i < 20), (i == LAT), (i >= LAT && i < 20 + LAT),
                 (i == LAT + LC));

    // 6. Three separated short presses
    pulse_cnt = 0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 30; i++)
        drive_step("t6_three", (i < 8), (i == LAT), (i >= LAT && i < 8 + LAT), 1'b0);
    check("t6_pulse_count", (pulse_cnt == 3), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
